// File: rtl/chan_scan_mux.sv
// Registered N-channel data multiplexer with manual select and round-robin
// auto-scan modes, presenting captured words on a valid/ready output stream.
module chan_scan_mux #(
  parameter int unsigned WIDTH    = 6,
  parameter int unsigned CHANNELS = 16,
  parameter int unsigned SEL_W    = 4,
  parameter int unsigned DWELL_W  = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [CHANNELS*WIDTH-1:0]    data_in,
  input  logic [SEL_W-1:0]             sel,
  input  logic                         mode,
  input  logic [CHANNELS-1:0]          chan_en,
  input  logic [DWELL_W-1:0]           dwell,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  output logic [SEL_W-1:0]             out_chan
);

  localparam int unsigned SUM_W = SEL_W + 1;

  typedef enum logic [1:0] {
    MAN   = 2'd0,
    SWAIT = 2'd1,
    SHOLD = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    ptr_q, ptr_d;
  logic [DWELL_W-1:0]  cnt_q, cnt_d;
  logic                valid_d;
  logic [WIDTH-1:0]    data_d;
  logic [SEL_W-1:0]    chan_d;

  logic [WIDTH-1:0]    chan_data [CHANNELS];
  logic                slot_free;
  logic                sel_ok;
  logic                hit;
  logic [SEL_W-1:0]    hit_idx;
  logic [SEL_W-1:0]    ptr_next;

  // Unpack the flat input bus into per-channel words.
  for (genvar k = 0; k < int'(CHANNELS); k++) begin : g_split
    assign chan_data[k] = data_in[k*WIDTH +: WIDTH];
  end

  assign slot_free = !out_valid || out_ready;
  assign sel_ok    = SUM_W'(sel) < SUM_W'(CHANNELS);
  assign ptr_next  = (out_chan == SEL_W'(CHANNELS - 1)) ? '0 : out_chan + SEL_W'(1);

  // First enabled channel at or after ptr, wrapping; lowest offset wins.
  always_comb begin
    logic [SUM_W-1:0] idx;
    hit     = 1'b0;
    hit_idx = '0;
    idx     = '0;
    for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
      idx = SUM_W'(ptr_q) + SUM_W'(i);
      if (idx >= SUM_W'(CHANNELS)) begin
        idx = idx - SUM_W'(CHANNELS);
      end
      if (chan_en[idx[SEL_W-1:0]]) begin
        hit     = 1'b1;
        hit_idx = idx[SEL_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= MAN;
      ptr_q     <= '0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      out_valid <= valid_d;
      out_data  <= data_d;
      out_chan  <= chan_d;
    end
  end

  // Next-state and output-register logic; a held word is never replaced.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    valid_d = out_valid;
    data_d  = out_data;
    chan_d  = out_chan;
    unique case (state_q)
      MAN: begin
        if (slot_free) begin
          if (mode) begin
            state_d = SWAIT;
            cnt_d   = dwell;
            valid_d = 1'b0;
          end else if (sel_ok) begin
            valid_d = 1'b1;
            data_d  = chan_data[sel];
            chan_d  = sel;
          end else begin
            valid_d = 1'b0;
          end
        end
      end
      SWAIT: begin
        valid_d = 1'b0;
        if (!mode) begin
          state_d = MAN;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end else if (hit) begin
          valid_d = 1'b1;
          data_d  = chan_data[hit_idx];
          chan_d  = hit_idx;
          state_d = SHOLD;
        end
      end
      SHOLD: begin
        if (out_valid && out_ready) begin
          ptr_d   = ptr_next;
          valid_d = 1'b0;
          if (mode) begin
            state_d = SWAIT;
            cnt_d   = dwell;
          end else begin
            state_d = MAN;
          end
        end
      end
      default: begin
        state_d = MAN;
      end
    endcase
  end

endmodule
